// File: rtl/seg7_scan_if.sv
// Signal bundle between the seven-segment scan controller and its host side
// (enables, nibble mux return path, display drive outputs).
interface seg7_scan_if;
    logic       en;
    logic       lz_blank;
    logic [3:0] nibble_in;
    logic [7:0] dp_in;
    logic [2:0] sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output en, lz_blank, nibble_in, dp_in,
        input  sel, an, seg, dp, frame_done
    );

    modport slave (
        input  en, lz_blank, nibble_in, dp_in,
        output sel, an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: MSD-first digit scan with
// inter-digit blanking, leading-zero suppression, decimal points and frame strobe.
//
// state | meaning
// IDLE  | scan disabled, display dark, sel parked on the top digit
// BLANK | display dark while the nibble mux settles on the new sel
// SHOW  | captured digit driven for DIGIT_TICKS cycles
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0] SHOW_LOAD  = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_TICKS - 1);
    localparam logic [2:0]    TOP_SEL    = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]    AN_OFF     = 8'hFF;
    localparam logic [6:0]    SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    sel_q, sel_nxt;
    logic [7:0]    an_q, an_nxt;
    logic [6:0]    seg_q, seg_nxt;
    logic          dp_q, dp_nxt;
    logic          fd_q, fd_nxt;
    logic          zrun, zrun_nxt;
    logic          dp_req;
    logic          blanked;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        sel_nxt   = sel_q;
        an_nxt    = an_q;
        seg_nxt   = seg_q;
        dp_nxt    = dp_q;
        zrun_nxt  = zrun;
        dp_req    = bus.dp_in[sel_q];
        blanked   = bus.lz_blank && zrun && (bus.nibble_in == 4'h0) && !dp_req
                    && (sel_q != 3'd0);

        if (!bus.en) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            sel_nxt   = TOP_SEL;
            an_nxt    = AN_OFF;
            seg_nxt   = SEG_OFF;
            dp_nxt    = 1'b1;
            zrun_nxt  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    timer_nxt = BLANK_LOAD;
                end
                BLANK: begin
                    if (timer == '0) begin
                        state_nxt = SHOW;
                        timer_nxt = SHOW_LOAD;
                        // A blanked digit simply leaves the dark BLANK drive in place.
                        if (!blanked) begin
                            an_nxt   = ~(8'd1 << sel_q);
                            seg_nxt  = decode(bus.nibble_in);
                            dp_nxt   = ~dp_req;
                            zrun_nxt = 1'b0;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        state_nxt = BLANK;
                        timer_nxt = BLANK_LOAD;
                        an_nxt    = AN_OFF;
                        seg_nxt   = SEG_OFF;
                        dp_nxt    = 1'b1;
                        if (sel_q == 3'd0) begin
                            sel_nxt  = TOP_SEL;
                            zrun_nxt = 1'b1;
                        end else begin
                            sel_nxt = sel_q - 3'd1;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Registered strobe lands on the final SHOW cycle of digit 0.
        fd_nxt = (state_nxt == SHOW) && (sel_nxt == 3'd0) && (timer_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            sel_q <= TOP_SEL;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
            zrun  <= 1'b1;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            sel_q <= sel_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
            fd_q  <= fd_nxt;
            zrun  <= zrun_nxt;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: position-arithmetic display model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int SLOT  = BT + DT;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        chk_on;
    int          checks = 0;
    int          errors = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_if bus ();

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External 8:1 nibble mux over a 16-bit display value.
    assign bus.nibble_in = 4'(value >> {bus.sel, 2'b00});

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Model: expected outputs from the cycle position within the enabled run.
    int         k;
    bit         lead;
    logic [2:0] m_sel;
    logic [7:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;
    logic       m_fd;

    always @(posedge clk or negedge rst_n) begin
        int pos, d, ph, s;
        logic [3:0] nib;
        bit dpb;
        if (!rst_n || !bus.en) begin
            k = 0; lead = 1;
            m_sel = 3'(ND - 1); m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
        end else begin
            k++;
            pos = (k - 1) % FRAME;
            d   = pos / SLOT;
            ph  = pos % SLOT;
            s   = ND - 1 - d;
            m_sel = 3'(s);
            m_fd  = (pos == FRAME - 1);
            if (ph < BT) begin
                m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
            end else if (ph == BT) begin
                if (s == ND - 1) lead = 1;
                nib = 4'(value >> (4 * s));
                dpb = bus.dp_in[s];
                if (bus.lz_blank && lead && nib == 4'h0 && !dpb && s != 0) begin
                    m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
                end else begin
                    m_an = ~(8'd1 << s); m_seg = seg_tbl[nib]; m_dp = ~dpb; lead = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model_sel", 32'(bus.sel), 32'(m_sel));
            cmp("model_an", 32'(bus.an), 32'(m_an));
            cmp("model_seg", 32'(bus.seg), 32'(m_seg));
            cmp("model_dp", 32'(bus.dp), 32'(m_dp));
            cmp("model_frame_done", 32'(bus.frame_done), 32'(m_fd));
        end
    end

    task automatic restart();
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
    endtask

    task automatic show_chk(input string nm, input logic [7:0] an, input logic [6:0] seg);
        cmp({nm, "_an"}, 32'(bus.an), 32'(an));
        cmp({nm, "_seg"}, 32'(bus.seg), 32'(seg));
    endtask

    initial begin
        int fd_cnt, fd_first, fd_second;
        rst_n = 1'b0; chk_on = 1'b0; value = '0;
        bus.en = 1'b0; bus.lz_blank = 1'b0; bus.dp_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; chk_on = 1'b1;
        cmp("rst_sel", 32'(bus.sel), 32'd3);
        show_chk("rst", 8'hFF, 7'h7F);
        cmp("rst_dp", 32'(bus.dp), 32'd1);
        cmp("rst_fd", 32'(bus.frame_done), 32'd0);

        // Plain scan of 0x1234
        value = 16'h1234;
        restart();
        fd_cnt = 0; fd_first = 0; fd_second = 0;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                fd_cnt++;
                if (fd_cnt == 1) fd_first = c;
                else if (fd_cnt == 2) fd_second = c;
            end
            if (c == 1) begin
                cmp("scan_c1_sel", 32'(bus.sel), 32'd3);
                show_chk("scan_c1", 8'hFF, 7'h7F);
            end
            if (c == 3)  show_chk("scan_d3", 8'hF7, 7'h79);
            if (c == 7)  cmp("scan_c7_sel", 32'(bus.sel), 32'd2);
            if (c == 9)  show_chk("scan_d2", 8'hFB, 7'h24);
            if (c == 15) show_chk("scan_d1", 8'hFD, 7'h30);
            if (c == 21) show_chk("scan_d0", 8'hFE, 7'h19);
        end
        cmp("fd_count", 32'(fd_cnt), 32'd2);
        cmp("fd_first", 32'(fd_first), 32'd24);
        cmp("fd_second", 32'(fd_second), 32'd48);

        // Async reset mid-frame, sampled between clock edges
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_sel", 32'(bus.sel), 32'd3);
        show_chk("arst", 8'hFF, 7'h7F);
        cmp("arst_dp", 32'(bus.dp), 32'd1);
        cmp("arst_fd", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Leading-zero blanking on 0x0050
        value = 16'h0050; bus.lz_blank = 1'b1;
        restart();
        repeat (3) @(negedge clk); show_chk("lz_d3", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("lz_d2", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("lz_d1", 8'hFD, 7'h12);
        repeat (6) @(negedge clk); show_chk("lz_d0", 8'hFE, 7'h40);

        // All zero: only digit 0 lit
        value = 16'h0000;
        restart();
        repeat (3) @(negedge clk); show_chk("z_d3", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("z_d2", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("z_d1", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("z_d0", 8'hFE, 7'h40);

        // Decimal point on digit 2 breaks the zero run
        bus.dp_in = 8'h04;
        restart();
        repeat (3) @(negedge clk); show_chk("dp_d3", 8'hFF, 7'h7F);
        repeat (6) @(negedge clk); show_chk("dp_d2", 8'hFB, 7'h40);
        cmp("dp_d2_dp", 32'(bus.dp), 32'd0);
        repeat (6) @(negedge clk); show_chk("dp_d1", 8'hFD, 7'h40);
        cmp("dp_d1_dp", 32'(bus.dp), 32'd1);
        repeat (6) @(negedge clk); show_chk("dp_d0", 8'hFE, 7'h40);

        // Disable during digit 1 SHOW, then re-enable
        bus.dp_in = 8'h00; bus.lz_blank = 1'b0; value = 16'h1234;
        restart();
        repeat (15) @(negedge clk); show_chk("dis_pre", 8'hFD, 7'h30);
        bus.en = 1'b0;
        @(negedge clk);
        show_chk("dis", 8'hFF, 7'h7F);
        cmp("dis_sel", 32'(bus.sel), 32'd3);
        cmp("dis_fd", 32'(bus.frame_done), 32'd0);
        bus.en = 1'b1;
        fd_cnt = 0;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c < FRAME && bus.frame_done) fd_cnt++;
            if (c == 2) show_chk("reen_c2", 8'hFF, 7'h7F);
            if (c == 3) show_chk("reen_d3", 8'hF7, 7'h79);
            if (c == FRAME) cmp("reen_fd_end", 32'(bus.frame_done), 32'd1);
        end
        cmp("reen_no_early_fd", 32'(fd_cnt), 32'd0);

        // Decode sweep on digit 0
        for (int i = 0; i < 16; i++) begin
            value = 16'(i);
            restart();
            repeat (3 * SLOT + BT + 1) @(negedge clk);
            show_chk($sformatf("dec_%0h", i), 8'hFE, seg_tbl[i]);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
